// File: rtl/atm_pkg.sv
// Shared constants and state encoding for the ATM account arbiter.
package atm_pkg;

   localparam int DEF_AW = 2;
   localparam int DEF_BW = 15;

   localparam logic [2:0] OP_BALANCE  = 3'b001;
   localparam logic [2:0] OP_WITHDRAW = 3'b010;
   localparam logic [2:0] OP_DEPOSIT  = 3'b011;
   localparam logic [2:0] OP_TRANSFER = 3'b100;

   localparam logic [2:0] ST_OK           = 3'b000;
   localparam logic [2:0] ST_INSUFFICIENT = 3'b001;
   localparam logic [2:0] ST_OVERFLOW     = 3'b010;
   localparam logic [2:0] ST_BAD_OP       = 3'b011;
   localparam logic [2:0] ST_SAME_ACCT    = 3'b100;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_SRC,
      S_RD_DST,
      S_CHK,
      S_WR_SRC,
      S_WR_DST,
      S_RESP
   } state_t;

   // True for the four opcodes the arbiter knows how to execute.
   function automatic logic op_is_valid(input logic [2:0] op);
      return (op == OP_BALANCE) || (op == OP_WITHDRAW) ||
             (op == OP_DEPOSIT) || (op == OP_TRANSFER);
   endfunction

endpackage

// File: rtl/atm_rr_arbiter.sv
// Round-robin grant among up to four requesters; the pointer moves past the
// winner only when the grant is actually taken.
module atm_rr_arbiter #(
   parameter int NUM_REQ = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic               advance,
   output logic [NUM_REQ-1:0] grant,
   output logic [1:0]         grant_idx,
   output logic               grant_any
);

   logic [1:0] ptr_reg;
   logic [3:0] valid_pad;
   logic [1:0] cand_idx [NUM_REQ];

   assign valid_pad = 4'(req_valid);

   // Candidate gi is the requester gi places after the pointer, wrapping.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
         logic [2:0] sum;
         assign sum = {1'b0, ptr_reg} + 3'(gi);
         assign cand_idx[gi] = (sum >= 3'(NUM_REQ)) ? 2'(sum - 3'(NUM_REQ)) : sum[1:0];
      end
   endgenerate

   // Pick the nearest asserted requester at or after the pointer.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = 2'd0;
      grant     = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (valid_pad[cand_idx[i]]) begin
            grant_any = 1'b1;
            grant_idx = cand_idx[i];
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_any && (grant_idx == 2'(i))) grant[i] = 1'b1;
      end
   end

   // Next search starts just past the requester that was served.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_reg <= 2'd0;
      end else if (advance) begin
         ptr_reg <= (grant_idx == 2'(NUM_REQ - 1)) ? 2'd0 : grant_idx + 2'd1;
      end
   end

endmodule

// File: rtl/atm_account_arbiter.sv
// Serialises ATM session requests onto the single-port balance memory and
// runs each one as an uninterruptible read-check-write sequence.
module atm_account_arbiter
   import atm_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int AW      = DEF_AW,
   parameter int BW      = DEF_BW
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [3*NUM_REQ-1:0]  req_op,
   input  logic [AW*NUM_REQ-1:0] req_src,
   input  logic [AW*NUM_REQ-1:0] req_dst,
   input  logic [BW*NUM_REQ-1:0] req_amount,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic                  rsp_valid,
   output logic [1:0]            rsp_id,
   output logic [2:0]            rsp_status,
   output logic [BW-1:0]         rsp_balance,
   output logic                  busy,
   output logic [AW-1:0]         mem_addr,
   output logic                  mem_we,
   output logic [BW-1:0]         mem_wdata,
   input  logic [BW-1:0]         mem_rdata
);

   state_t        state_reg;
   logic [2:0]    op_reg;
   logic [AW-1:0] src_reg, dst_reg;
   logic [BW-1:0] amount_reg, src_bal_reg, dst_new_reg, result_reg;
   logic [1:0]    id_reg;

   logic [NUM_REQ-1:0] grant;
   logic [1:0]         grant_idx;
   logic               grant_any, accept;

   logic [2:0]    op_arr  [4];
   logic [AW-1:0] src_arr [4];
   logic [AW-1:0] dst_arr [4];
   logic [BW-1:0] amt_arr [4];

   // Unpack the flat request buses so the winner's payload is a plain index.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_unpack
         if (gi < NUM_REQ) begin : g_live
            assign op_arr[gi]  = req_op[gi*3 +: 3];
            assign src_arr[gi] = req_src[gi*AW +: AW];
            assign dst_arr[gi] = req_dst[gi*AW +: AW];
            assign amt_arr[gi] = req_amount[gi*BW +: BW];
         end else begin : g_tie
            assign op_arr[gi]  = 3'b000;
            assign src_arr[gi] = '0;
            assign dst_arr[gi] = '0;
            assign amt_arr[gi] = '0;
         end
      end
   endgenerate

   atm_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .advance   (accept),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_any (grant_any)
   );

   // Grants only happen from IDLE, which is what makes each request atomic.
   assign accept    = (state_reg == S_IDLE) && grant_any && !reset;
   assign req_ready = accept ? grant : '0;
   assign busy      = (state_reg != S_IDLE);

   // In CHK the source balance comes straight off the memory for single-account
   // ops; a transfer already captured it during RD_DST and is now reading dst.
   logic [BW-1:0] chk_src_bal, debit_bal;
   logic [BW:0]   dep_sum, xfer_sum;
   assign chk_src_bal = (op_reg == OP_TRANSFER) ? src_bal_reg : mem_rdata;
   assign debit_bal   = chk_src_bal - amount_reg;
   assign dep_sum     = {1'b0, chk_src_bal} + {1'b0, amount_reg};
   assign xfer_sum    = {1'b0, mem_rdata} + {1'b0, amount_reg};

   // Transaction sequencer; all memory and response outputs are registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= S_IDLE;
         op_reg      <= 3'b000;
         src_reg     <= '0;
         dst_reg     <= '0;
         amount_reg  <= '0;
         src_bal_reg <= '0;
         dst_new_reg <= '0;
         result_reg  <= '0;
         id_reg      <= 2'd0;
         rsp_valid   <= 1'b0;
         rsp_id      <= 2'd0;
         rsp_status  <= 3'b000;
         rsp_balance <= '0;
         mem_addr    <= '0;
         mem_we      <= 1'b0;
         mem_wdata   <= '0;
      end else begin
         rsp_valid   <= 1'b0;
         rsp_id      <= 2'd0;
         rsp_status  <= 3'b000;
         rsp_balance <= '0;
         mem_addr    <= '0;
         mem_we      <= 1'b0;
         mem_wdata   <= '0;
         case (state_reg)
            S_IDLE: begin
               if (accept) begin
                  op_reg     <= op_arr[grant_idx];
                  src_reg    <= src_arr[grant_idx];
                  dst_reg    <= dst_arr[grant_idx];
                  amount_reg <= amt_arr[grant_idx];
                  id_reg     <= grant_idx;
                  if (!op_is_valid(op_arr[grant_idx])) begin
                     state_reg  <= S_RESP;
                     rsp_valid  <= 1'b1;
                     rsp_id     <= grant_idx;
                     rsp_status <= ST_BAD_OP;
                  end else if ((op_arr[grant_idx] == OP_TRANSFER) &&
                               (src_arr[grant_idx] == dst_arr[grant_idx])) begin
                     state_reg  <= S_RESP;
                     rsp_valid  <= 1'b1;
                     rsp_id     <= grant_idx;
                     rsp_status <= ST_SAME_ACCT;
                  end else begin
                     state_reg <= S_RD_SRC;
                     mem_addr  <= src_arr[grant_idx];
                  end
               end
            end
            S_RD_SRC: begin
               if (op_reg == OP_TRANSFER) begin
                  state_reg <= S_RD_DST;
                  mem_addr  <= dst_reg;
               end else begin
                  state_reg <= S_CHK;
               end
            end
            S_RD_DST: begin
               src_bal_reg <= mem_rdata;
               state_reg   <= S_CHK;
            end
            S_CHK: begin
               rsp_id      <= id_reg;
               rsp_balance <= chk_src_bal;
               if ((op_reg == OP_BALANCE) ||
                   ((op_reg != OP_DEPOSIT) && (amount_reg > chk_src_bal)) ||
                   ((op_reg == OP_DEPOSIT) && dep_sum[BW]) ||
                   ((op_reg == OP_TRANSFER) && xfer_sum[BW])) begin
                  // Balance query or a failed check: answer with the pre-op value.
                  state_reg <= S_RESP;
                  rsp_valid <= 1'b1;
                  if (op_reg == OP_BALANCE)
                     rsp_status <= ST_OK;
                  else if ((op_reg != OP_DEPOSIT) && (amount_reg > chk_src_bal))
                     rsp_status <= ST_INSUFFICIENT;
                  else
                     rsp_status <= ST_OVERFLOW;
               end else begin
                  state_reg   <= S_WR_SRC;
                  mem_we      <= 1'b1;
                  mem_addr    <= src_reg;
                  mem_wdata   <= (op_reg == OP_DEPOSIT) ? dep_sum[BW-1:0] : debit_bal;
                  result_reg  <= (op_reg == OP_DEPOSIT) ? dep_sum[BW-1:0] : debit_bal;
                  dst_new_reg <= xfer_sum[BW-1:0];
                  rsp_id      <= 2'd0;
                  rsp_balance <= '0;
               end
            end
            S_WR_SRC: begin
               if (op_reg == OP_TRANSFER) begin
                  state_reg <= S_WR_DST;
                  mem_we    <= 1'b1;
                  mem_addr  <= dst_reg;
                  mem_wdata <= dst_new_reg;
               end else begin
                  state_reg   <= S_RESP;
                  rsp_valid   <= 1'b1;
                  rsp_id      <= id_reg;
                  rsp_balance <= result_reg;
               end
            end
            S_WR_DST: begin
               state_reg   <= S_RESP;
               rsp_valid   <= 1'b1;
               rsp_id      <= id_reg;
               rsp_balance <= result_reg;
            end
            default: begin
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_atm_account_arbiter.sv
// Directed bench for atm_account_arbiter with a registered-read account memory.
module tb_atm_account_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req_valid;
   logic [5:0]  req_op;
   logic [3:0]  req_src, req_dst;
   logic [29:0] req_amount;
   logic [1:0]  req_ready;
   logic        rsp_valid;
   logic [1:0]  rsp_id;
   logic [2:0]  rsp_status;
   logic [14:0] rsp_balance;
   logic        busy;
   logic [1:0]  mem_addr;
   logic        mem_we;
   logic [14:0] mem_wdata;
   logic [14:0] mem_rdata;

   logic [14:0] mem [4];
   logic        pre_we = 1'b0;
   logic [1:0]  pre_addr = 2'd0;
   logic [14:0] pre_data = 15'd0;

   int n_vec = 0;
   int n_err = 0;

   // Captured trace of the last transaction.
   int          k, rsp_cyc, nw;
   logic [1:0]  ready_seen;
   logic [2:0]  st_got;
   logic [14:0] bal_got;
   logic [1:0]  id_got;
   int          wr_cyc [4];
   logic [1:0]  wr_addr [4];
   logic [14:0] wr_data [4];
   bit          busy_gap;

   atm_account_arbiter dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
      .req_src(req_src), .req_dst(req_dst), .req_amount(req_amount),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
      .rsp_status(rsp_status), .rsp_balance(rsp_balance), .busy(busy),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (pre_we) mem[pre_addr] <= pre_data;
      else if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   task automatic preload(input logic [1:0] a, input logic [14:0] d);
      @(negedge clk);
      pre_we = 1'b1; pre_addr = a; pre_data = d;
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   // Issue one request on requester r and record grant, writes and response.
   task automatic do_txn(input int r, input logic [2:0] op, input logic [1:0] src,
                         input logic [1:0] dst, input logic [14:0] amt);
      bit done;
      k = -1; rsp_cyc = -1; nw = 0; ready_seen = 2'b00; busy_gap = 0; done = 0;
      st_got = 3'b000; bal_got = 15'd0; id_got = 2'd0;
      @(negedge clk);
      req_op[r*3 +: 3] = op; req_src[r*2 +: 2] = src; req_dst[r*2 +: 2] = dst;
      req_amount[r*15 +: 15] = amt; req_valid[r] = 1'b1;
      for (int i = 0; i < 16 && !done; i++) begin
         #1;
         if (k < 0 && req_ready != 2'b00) begin k = 0; ready_seen = req_ready; end
         if (k >= 1 && !busy) busy_gap = 1;
         if (k >= 0 && mem_we && nw < 4) begin
            wr_cyc[nw] = k; wr_addr[nw] = mem_addr; wr_data[nw] = mem_wdata; nw++;
         end
         if (k >= 0 && rsp_valid) begin
            rsp_cyc = k; st_got = rsp_status; bal_got = rsp_balance; id_got = rsp_id; done = 1;
         end
         @(negedge clk);
         if (k == 0) begin
            req_valid[r] = 1'b0; req_op[r*3 +: 3] = 3'b111;
            req_src[r*2 +: 2] = ~src; req_amount[r*15 +: 15] = ~amt;
         end
         if (k >= 0) k++;
      end
      $display("txn req%0d op=%0d src=%0d dst=%0d amt=%h -> rsp_cyc=%0d status=%0d bal=%h id=%0d writes=%0d",
               r, op, src, dst, amt, rsp_cyc, st_got, bal_got, id_got, nw);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      n_vec++; if ({rsp_valid, busy, mem_we} !== 3'b000) begin n_err++; $display("FAIL rst_flags: got %b expected 000", {rsp_valid, busy, mem_we}); end
      n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL rst_ready: got %b expected 00", req_ready); end
      n_vec++; if ({mem_addr, mem_wdata} !== 17'd0) begin n_err++; $display("FAIL rst_mem: got %h expected 0", {mem_addr, mem_wdata}); end
      n_vec++; if ({rsp_id, rsp_status, rsp_balance} !== 20'd0) begin n_err++; $display("FAIL rst_rsp: got %h expected 0", {rsp_id, rsp_status, rsp_balance}); end
      $display("reset check done");
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_withdraw;
      preload(2'd0, 15'h0100);
      do_txn(0, 3'b010, 2'd0, 2'd0, 15'h0044);
      n_vec++; if (ready_seen !== 2'b01) begin n_err++; $display("FAIL wd_ready: got %b expected 01", ready_seen); end
      n_vec++; if (nw !== 1) begin n_err++; $display("FAIL wd_nwrites: got %0d expected 1", nw); end
      n_vec++; if ({wr_cyc[0], wr_addr[0], wr_data[0]} !== {32'd3, 2'd0, 15'h00BC}) begin n_err++; $display("FAIL wd_write: got cyc %0d addr %0d data %h expected cyc 3 addr 0 data 00bc", wr_cyc[0], wr_addr[0], wr_data[0]); end
      n_vec++; if (rsp_cyc !== 4) begin n_err++; $display("FAIL wd_rsp_cycle: got %0d expected 4", rsp_cyc); end
      n_vec++; if ({st_got, bal_got, id_got} !== {3'd0, 15'h00BC, 2'd0}) begin n_err++; $display("FAIL wd_rsp: got st %0d bal %h id %0d expected st 0 bal 00bc id 0", st_got, bal_got, id_got); end
      n_vec++; if (busy_gap !== 1'b0) begin n_err++; $display("FAIL wd_busy: got gap %0d expected 0", busy_gap); end
      n_vec++; if (mem[0] !== 15'h00BC) begin n_err++; $display("FAIL wd_mem: got %h expected 00bc", mem[0]); end
      do_txn(0, 3'b010, 2'd0, 2'd0, 15'h2334);
      n_vec++; if (rsp_cyc !== 3) begin n_err++; $display("FAIL ins_rsp_cycle: got %0d expected 3", rsp_cyc); end
      n_vec++; if ({st_got, bal_got} !== {3'd1, 15'h00BC}) begin n_err++; $display("FAIL ins_rsp: got st %0d bal %h expected st 1 bal 00bc", st_got, bal_got); end
      n_vec++; if (nw !== 0) begin n_err++; $display("FAIL ins_nwrites: got %0d expected 0", nw); end
   endtask

   task automatic test_deposit;
      preload(2'd1, 15'h7FF0);
      do_txn(1, 3'b011, 2'd1, 2'd0, 15'h0022);
      n_vec++; if (ready_seen !== 2'b10) begin n_err++; $display("FAIL dep_ready: got %b expected 10", ready_seen); end
      n_vec++; if (rsp_cyc !== 3) begin n_err++; $display("FAIL ovf_rsp_cycle: got %0d expected 3", rsp_cyc); end
      n_vec++; if ({st_got, bal_got, id_got} !== {3'd2, 15'h7FF0, 2'd1}) begin n_err++; $display("FAIL ovf_rsp: got st %0d bal %h id %0d expected st 2 bal 7ff0 id 1", st_got, bal_got, id_got); end
      n_vec++; if (nw !== 0) begin n_err++; $display("FAIL ovf_nwrites: got %0d expected 0", nw); end
      do_txn(1, 3'b011, 2'd1, 2'd0, 15'h000F);
      n_vec++; if (rsp_cyc !== 4) begin n_err++; $display("FAIL dep_rsp_cycle: got %0d expected 4", rsp_cyc); end
      n_vec++; if ({st_got, bal_got} !== {3'd0, 15'h7FFF}) begin n_err++; $display("FAIL dep_rsp: got st %0d bal %h expected st 0 bal 7fff", st_got, bal_got); end
      n_vec++; if ({nw, wr_cyc[0], wr_addr[0], wr_data[0]} !== {32'd1, 32'd3, 2'd1, 15'h7FFF}) begin n_err++; $display("FAIL dep_write: got n %0d cyc %0d addr %0d data %h expected n 1 cyc 3 addr 1 data 7fff", nw, wr_cyc[0], wr_addr[0], wr_data[0]); end
   endtask

   task automatic test_transfer;
      preload(2'd0, 15'h0100);
      preload(2'd2, 15'h0010);
      do_txn(0, 3'b100, 2'd0, 2'd2, 15'h00C8);
      n_vec++; if (nw !== 2) begin n_err++; $display("FAIL xfer_nwrites: got %0d expected 2", nw); end
      n_vec++; if ({wr_cyc[0], wr_addr[0], wr_data[0]} !== {32'd4, 2'd0, 15'h0038}) begin n_err++; $display("FAIL xfer_wr_src: got cyc %0d addr %0d data %h expected cyc 4 addr 0 data 0038", wr_cyc[0], wr_addr[0], wr_data[0]); end
      n_vec++; if ({wr_cyc[1], wr_addr[1], wr_data[1]} !== {32'd5, 2'd2, 15'h00D8}) begin n_err++; $display("FAIL xfer_wr_dst: got cyc %0d addr %0d data %h expected cyc 5 addr 2 data 00d8", wr_cyc[1], wr_addr[1], wr_data[1]); end
      n_vec++; if ({rsp_cyc, st_got, bal_got} !== {32'd6, 3'd0, 15'h0038}) begin n_err++; $display("FAIL xfer_rsp: got cyc %0d st %0d bal %h expected cyc 6 st 0 bal 0038", rsp_cyc, st_got, bal_got); end
      // acct1 = 0x7FFF, so crediting it by one must overflow without writes.
      do_txn(1, 3'b100, 2'd2, 2'd1, 15'h0001);
      n_vec++; if ({rsp_cyc, st_got, bal_got} !== {32'd4, 3'd2, 15'h00D8}) begin n_err++; $display("FAIL xovf_rsp: got cyc %0d st %0d bal %h expected cyc 4 st 2 bal 00d8", rsp_cyc, st_got, bal_got); end
      n_vec++; if (nw !== 0) begin n_err++; $display("FAIL xovf_nwrites: got %0d expected 0", nw); end
   endtask

   task automatic test_rejects;
      do_txn(0, 3'b100, 2'd0, 2'd0, 15'h0005);
      n_vec++; if ({rsp_cyc, st_got, bal_got, nw} !== {32'd1, 3'd4, 15'h0000, 32'd0}) begin n_err++; $display("FAIL same_acct: got cyc %0d st %0d bal %h n %0d expected cyc 1 st 4 bal 0 n 0", rsp_cyc, st_got, bal_got, nw); end
      do_txn(1, 3'b111, 2'd1, 2'd2, 15'h0003);
      n_vec++; if ({rsp_cyc, st_got, bal_got, id_got, nw} !== {32'd1, 3'd3, 15'h0000, 2'd1, 32'd0}) begin n_err++; $display("FAIL bad_op: got cyc %0d st %0d bal %h id %0d n %0d expected cyc 1 st 3 bal 0 id 1 n 0", rsp_cyc, st_got, bal_got, id_got, nw); end
      preload(2'd3, 15'h1234);
      do_txn(0, 3'b010, 2'd3, 2'd0, 15'h0000);
      n_vec++; if ({rsp_cyc, st_got, bal_got} !== {32'd4, 3'd0, 15'h1234}) begin n_err++; $display("FAIL zero_amt_rsp: got cyc %0d st %0d bal %h expected cyc 4 st 0 bal 1234", rsp_cyc, st_got, bal_got); end
      n_vec++; if ({nw, wr_addr[0], wr_data[0]} !== {32'd1, 2'd3, 15'h1234}) begin n_err++; $display("FAIL zero_amt_write: got n %0d addr %0d data %h expected n 1 addr 3 data 1234", nw, wr_addr[0], wr_data[0]); end
   endtask

   task automatic test_back_to_back;
      int         ng, nr, waited;
      logic [1:0] g_idx [8];
      int         g_cyc [8];
      logic [1:0] r_id  [8];
      logic [14:0] r_bal [8];
      bit         multi;
      ng = 0; nr = 0; multi = 0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      req_op = {3'b001, 3'b001}; req_src = {2'd1, 2'd2}; req_dst = 4'd0; req_amount = 30'd0;
      req_valid = 2'b11;
      for (int c = 0; c < 24; c++) begin
         #1;
         if (req_ready == 2'b11) multi = 1;
         if (req_ready != 2'b00 && ng < 8) begin
            g_idx[ng] = req_ready[1] ? 2'd1 : 2'd0; g_cyc[ng] = c; ng++;
         end
         if (rsp_valid && nr < 8) begin r_id[nr] = rsp_id; r_bal[nr] = rsp_balance; nr++; end
         @(negedge clk);
      end
      req_valid = 2'b00;
      waited = 0;
      while (busy && waited < 10) begin @(negedge clk); waited++; end
      $display("back_to_back grants=%0d responses=%0d", ng, nr);
      n_vec++; if (ng < 4 || nr < 4) begin n_err++; $display("FAIL b2b_count: got grants %0d rsps %0d expected at least 4 each", ng, nr); end
      else begin
         n_vec++; if ({g_idx[0], g_idx[1], g_idx[2], g_idx[3]} !== 8'b00_01_00_01) begin n_err++; $display("FAIL b2b_order: got %0d %0d %0d %0d expected 0 1 0 1", g_idx[0], g_idx[1], g_idx[2], g_idx[3]); end
         n_vec++; if ({g_cyc[1] - g_cyc[0], g_cyc[2] - g_cyc[1]} !== {32'd4, 32'd4}) begin n_err++; $display("FAIL b2b_spacing: got %0d %0d expected 4 4", g_cyc[1] - g_cyc[0], g_cyc[2] - g_cyc[1]); end
         n_vec++; if ({r_id[0], r_id[1], r_id[2], r_id[3]} !== {g_idx[0], g_idx[1], g_idx[2], g_idx[3]}) begin n_err++; $display("FAIL b2b_rsp_id: got %0d %0d %0d %0d expected 0 1 0 1", r_id[0], r_id[1], r_id[2], r_id[3]); end
         n_vec++; if ({r_bal[0], r_bal[1]} !== {15'h00D8, 15'h7FFF}) begin n_err++; $display("FAIL b2b_balance: got %h %h expected 00d8 7fff", r_bal[0], r_bal[1]); end
      end
      n_vec++; if (multi !== 1'b0) begin n_err++; $display("FAIL b2b_onehot: got multi-grant %0d expected 0", multi); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got busy %0d expected 0", busy); end
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      req_op[2:0] = 3'b010; req_src[1:0] = 2'd2; req_amount[14:0] = 15'h0008; req_valid[0] = 1'b1;
      #1;
      n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL rm_grant: got %b expected 01", req_ready); end
      @(negedge clk);
      req_valid[0] = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      #1;
      $display("reset in CHK: busy=%0d we=%0d rsp_valid=%0d", busy, mem_we, rsp_valid);
      n_vec++; if ({busy, mem_we, rsp_valid, req_ready} !== 5'b0) begin n_err++; $display("FAIL rm_flags: got %b expected 00000", {busy, mem_we, rsp_valid, req_ready}); end
      n_vec++; if ({mem_addr, mem_wdata, rsp_balance, rsp_status} !== 35'd0) begin n_err++; $display("FAIL rm_outputs: got %h expected 0", {mem_addr, mem_wdata, rsp_balance, rsp_status}); end
      reset = 1'b0;
      repeat (3) @(negedge clk);
      n_vec++; if (mem[2] !== 15'h00D8) begin n_err++; $display("FAIL rm_no_write: got %h expected 00d8", mem[2]); end
      do_txn(1, 3'b001, 2'd3, 2'd0, 15'h0000);
      n_vec++; if (ready_seen !== 2'b10) begin n_err++; $display("FAIL rm_req1_grant: got %b expected 10", ready_seen); end
      n_vec++; if ({rsp_cyc, st_got, bal_got, id_got} !== {32'd3, 3'd0, 15'h1234, 2'd1}) begin n_err++; $display("FAIL rm_req1_rsp: got cyc %0d st %0d bal %h id %0d expected cyc 3 st 0 bal 1234 id 1", rsp_cyc, st_got, bal_got, id_got); end
   endtask

   initial begin
      reset = 1'b1;
      req_valid = 2'b00; req_op = 6'd0; req_src = 4'd0; req_dst = 4'd0; req_amount = 30'd0;
      test_reset;
      test_withdraw;
      test_deposit;
      test_transfer;
      test_rejects;
      test_back_to_back;
      test_reset_mid;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
